// File: rtl/clock_trig_multi.sv
// Multi-channel programmable periodic trigger generator.
// Each channel runs an independent IDLE/DELAY/RUN/DONE FSM with shadowed configuration.
module clock_trig_multi #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned GAP_W = 20,
    parameter int unsigned WID_W = 8,
    parameter int unsigned NB_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_live,
    input  logic                   sync,
    input  logic [NCH-1:0]         user_ena,
    input  logic [NCH*GAP_W-1:0]   user_gap,
    input  logic [NCH*GAP_W-1:0]   user_ofs,
    input  logic [NCH*WID_W-1:0]   user_wid,
    input  logic [NCH*NB_W-1:0]    user_nburst,
    output logic [NCH-1:0]         out,
    output logic [NCH-1:0]         active,
    output logic [NCH-1:0]         done
);

    localparam int unsigned CW = GAP_W + WID_W;

    typedef enum logic [1:0] {StIdle, StDelay, StRun, StDone} state_e;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        state_e           state_q, state_d;
        logic [GAP_W-1:0] phase_q, phase_d;
        logic [GAP_W-1:0] dly_q, dly_d;
        logic [GAP_W-1:0] gap_q, gap_d;
        logic [WID_W-1:0] wid_q, wid_d;
        logic [NB_W-1:0]  nb_q, nb_d;
        logic [NB_W-1:0]  cnt_q, cnt_d;
        logic             out_q, out_d;
        logic             act_q, act_d;
        logic             done_q, done_d;

        logic [GAP_W-1:0] cfg_gap, cfg_ofs;
        logic [WID_W-1:0] cfg_wid;
        logic [NB_W-1:0]  cfg_nb;
        logic [GAP_W-1:0] phase_inc;
        logic [NB_W-1:0]  cnt_inc;
        logic             in_width;

        assign cfg_gap   = user_gap[c*GAP_W +: GAP_W];
        assign cfg_ofs   = user_ofs[c*GAP_W +: GAP_W];
        assign cfg_wid   = user_wid[c*WID_W +: WID_W];
        assign cfg_nb    = user_nburst[c*NB_W +: NB_W];
        assign phase_inc = phase_q + GAP_W'(1);
        assign cnt_inc   = cnt_q + NB_W'(1);
        // Phase 0 is always high, so wid=0 acts as 1 and wid>gap saturates to continuous high.
        assign in_width  = CW'(phase_inc) < CW'(wid_q);

        always_comb begin
            state_d = state_q;
            phase_d = phase_q;
            dly_d   = dly_q;
            gap_d   = gap_q;
            wid_d   = wid_q;
            nb_d    = nb_q;
            cnt_d   = cnt_q;
            out_d   = 1'b0;
            act_d   = 1'b0;
            done_d  = 1'b0;

            if (!in_live || !user_ena[c]) begin
                state_d = StIdle;
            end else if (sync || state_q == StIdle) begin
                gap_d   = cfg_gap;
                wid_d   = cfg_wid;
                nb_d    = cfg_nb;
                cnt_d   = '0;
                phase_d = '0;
                act_d   = 1'b1;
                if (cfg_ofs == '0) begin
                    state_d = StRun;
                    out_d   = 1'b1;
                end else begin
                    state_d = StDelay;
                    dly_d   = cfg_ofs;
                end
            end else begin
                unique case (state_q)
                    StDelay: begin
                        act_d = 1'b1;
                        if (dly_q == GAP_W'(1)) begin
                            state_d = StRun;
                            phase_d = '0;
                            out_d   = 1'b1;
                        end else begin
                            dly_d = dly_q - GAP_W'(1);
                        end
                    end
                    StRun: begin
                        if (phase_q == gap_q) begin
                            phase_d = '0;
                            if (nb_q != '0 && cnt_inc == nb_q) begin
                                state_d = StDone;
                                done_d  = 1'b1;
                                cnt_d   = cnt_inc;
                            end else begin
                                act_d = 1'b1;
                                out_d = 1'b1;
                                // Continuous mode never counts, so the counter cannot wrap.
                                if (nb_q != '0) cnt_d = cnt_inc;
                            end
                        end else begin
                            phase_d = phase_inc;
                            act_d   = 1'b1;
                            out_d   = in_width;
                        end
                    end
                    StDone: begin
                        state_d = StDone;
                    end
                    default: begin
                        state_d = StIdle;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StIdle;
                phase_q <= '0;
                dly_q   <= '0;
                gap_q   <= '0;
                wid_q   <= '0;
                nb_q    <= '0;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                act_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                phase_q <= phase_d;
                dly_q   <= dly_d;
                gap_q   <= gap_d;
                wid_q   <= wid_d;
                nb_q    <= nb_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                act_q   <= act_d;
                done_q  <= done_d;
            end
        end

        assign out[c]    = out_q;
        assign active[c] = act_q;
        assign done[c]   = done_q;
    end

endmodule

// File: tb/tb_clock_trig_multi.sv
// Scoreboard bench for clock_trig_multi: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_clock_trig_multi;

    localparam int NCH   = 4;
    localparam int GAP_W = 20;
    localparam int WID_W = 8;
    localparam int NB_W  = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_live;
    logic                 sync;
    logic [NCH-1:0]       user_ena;
    logic [NCH*GAP_W-1:0] user_gap;
    logic [NCH*GAP_W-1:0] user_ofs;
    logic [NCH*WID_W-1:0] user_wid;
    logic [NCH*NB_W-1:0]  user_nburst;
    logic [NCH-1:0]       out;
    logic [NCH-1:0]       active;
    logic [NCH-1:0]       done;

    clock_trig_multi #(
        .NCH   (NCH),
        .GAP_W (GAP_W),
        .WID_W (WID_W),
        .NB_W  (NB_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_live     (in_live),
        .sync        (sync),
        .user_ena    (user_ena),
        .user_gap    (user_gap),
        .user_ofs    (user_ofs),
        .user_wid    (user_wid),
        .user_nburst (user_nburst),
        .out         (out),
        .active      (active),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             t;
        logic [NCH-1:0] o;
        logic [NCH-1:0] a;
        logic [NCH-1:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Current programmed values and the values the bench expects latched per channel.
    int cur_gap[NCH], cur_ofs[NCH], cur_wid[NCH], cur_nb[NCH];
    int sh_gap[NCH], sh_ofs[NCH], sh_wid[NCH], sh_nb[NCH];
    int e0[NCH];

    // Spec timing model: returns {out, active, done} t cycles after the start edge.
    function automatic logic [2:0] exp_ch(int t, int ofs, int gap, int wid, int nb);
        int per, weff, u, k, p;
        if (t < 0) return 3'b000;
        per  = gap + 1;
        weff = (wid == 0) ? 1 : wid;
        if (weff > per) weff = per;
        if (t < ofs) return 3'b010;
        u = t - ofs;
        k = u / per;
        p = u % per;
        if (nb != 0 && k >= nb) return (u == nb * per) ? 3'b001 : 3'b000;
        return {(p < weff), 1'b1, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if ({out, active, done} !== {mon_e.o, mon_e.a, mon_e.d}) begin
                errors++;
                $display("FAIL outputs@cycle%0d: got out=%b active=%b done=%b, want out=%b active=%b done=%b",
                         mon_e.t, out, active, done, mon_e.o, mon_e.a, mon_e.d);
            end
        end
    end

    task automatic check_now(string name);
        checks++;
        if ({out, active, done} !== '0) begin
            errors++;
            $display("FAIL %s: got out=%b active=%b done=%b, want all zero",
                     name, out, active, done);
        end
    endtask

    task automatic set_cfg(int c, int gap, int ofs, int wid, int nb);
        user_gap[c*GAP_W +: GAP_W]  = GAP_W'(gap);
        user_ofs[c*GAP_W +: GAP_W]  = GAP_W'(ofs);
        user_wid[c*WID_W +: WID_W]  = WID_W'(wid);
        user_nburst[c*NB_W +: NB_W] = NB_W'(nb);
        cur_gap[c] = gap;
        cur_ofs[c] = ofs;
        cur_wid[c] = wid;
        cur_nb[c]  = nb;
    endtask

    task automatic latch(int c);
        sh_gap[c] = cur_gap[c];
        sh_ofs[c] = cur_ofs[c];
        sh_wid[c] = cur_wid[c];
        sh_nb[c]  = cur_nb[c];
        e0[c]     = cyc;
    endtask

    task automatic arm(int c);
        user_ena[c] = 1'b1;
        if (in_live && rst_n) latch(c);
    endtask

    task automatic disarm_all();
        user_ena = '0;
        for (int c = 0; c < NCH; c++) e0[c] = -1;
    endtask

    // Push the expectation for the coming edge, then advance past it.
    task automatic tick();
        exp_t       e;
        logic [2:0] r;
        e.t = cyc;
        for (int c = 0; c < NCH; c++) begin
            r = exp_ch((e0[c] < 0) ? -1 : cyc - e0[c], sh_ofs[c], sh_gap[c], sh_wid[c], sh_nb[c]);
            e.o[c] = r[2];
            e.a[c] = r[1];
            e.d[c] = r[0];
        end
        sb.push_back(e);
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic do_sync();
        sync = 1'b1;
        for (int c = 0; c < NCH; c++) if (user_ena[c]) latch(c);
        tick();
        sync = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b1;
        in_live     = 1'b0;
        sync        = 1'b0;
        user_ena    = '0;
        user_gap    = '0;
        user_ofs    = '0;
        user_wid    = '0;
        user_nburst = '0;
        for (int c = 0; c < NCH; c++) begin
            e0[c] = -1;
            set_cfg(c, 0, 0, 0, 0);
            latch(c);
            e0[c] = -1;
        end
        #1 rst_n = 1'b0;
        #1 check_now("reset_state");
        @(negedge clk);
        #1;
        rst_n   = 1'b1;
        in_live = 1'b1;
        tick();

        // Legacy behaviour: one-cycle pulse every 5 cycles starting at E0.
        set_cfg(0, 4, 0, 1, 0);
        arm(0);
        repeat (15) tick();
        disarm_all();
        tick();

        // Offset, width and finite burst with DONE hold.
        set_cfg(1, 9, 3, 4, 3);
        arm(1);
        repeat (40) tick();
        disarm_all();
        tick();

        // Width clamps.
        set_cfg(2, 2, 0, 0, 0);
        arm(2);
        repeat (7) tick();
        disarm_all();
        tick();
        set_cfg(2, 2, 0, 200, 0);
        arm(2);
        repeat (5) tick();
        disarm_all();
        tick();
        set_cfg(2, 0, 0, 1, 0);
        arm(2);
        repeat (4) tick();
        disarm_all();
        tick();

        // Shadowing: new gap ignored until the enable is cycled.
        set_cfg(2, 7, 0, 1, 0);
        arm(2);
        repeat (5) tick();
        set_cfg(2, 3, 0, 1, 0);
        repeat (15) tick();
        disarm_all();
        tick();
        arm(2);
        repeat (10) tick();
        disarm_all();
        tick();

        // Sync realigns running channels and restarts a channel sitting in DONE.
        set_cfg(0, 4, 0, 1, 0);
        set_cfg(3, 1, 0, 1, 1);
        arm(0);
        arm(3);
        repeat (2) tick();
        set_cfg(1, 6, 0, 1, 0);
        arm(1);
        repeat (7) tick();
        do_sync();
        repeat (10) tick();
        disarm_all();
        tick();

        // Gate drop in the middle of a wide pulse, then restart on gate return.
        set_cfg(1, 9, 0, 6, 0);
        arm(0);
        arm(1);
        repeat (3) tick();
        in_live = 1'b0;
        for (int c = 0; c < NCH; c++) e0[c] = -1;
        repeat (3) tick();
        in_live = 1'b1;
        for (int c = 0; c < NCH; c++) if (user_ena[c]) latch(c);
        repeat (8) tick();
        disarm_all();
        tick();

        // Asynchronous reset during DELAY, then offset honoured from the new E0.
        set_cfg(1, 3, 5, 2, 0);
        arm(1);
        repeat (3) tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        for (int c = 0; c < NCH; c++) e0[c] = -1;
        #1 check_now("async_reset_mid_delay");
        repeat (2) tick();
        rst_n = 1'b1;
        for (int c = 0; c < NCH; c++) if (user_ena[c]) latch(c);
        repeat (12) tick();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_trig_multi.md
# clock_trig_multi

Multi-channel programmable periodic trigger generator: the parametrised successor of the single-channel clock trigger. It sits between the run-control register bank (`in_live`, per-channel user settings) and the trigger-decision logic. Each channel emits periodic pulses with programmable period, phase offset, pulse width and an optional finite burst count. A global `sync` input realigns all running channels.

## Interface
Parameters:
- `NCH`, 4: number of independent channels.
- `GAP_W`, 20: width of gap and offset fields.
- `WID_W`, 8: width of pulse-width field.
- `NB_W`, 16: width of burst-count field.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_live`  in  1  global run gate; low forces every channel to IDLE (synchronous).
- `sync`  in  1  global realign strobe, one cycle.
- `user_ena`  in  NCH  per-channel enable.
- `user_gap`  in  NCH*GAP_W  channel c at bits [c*GAP_W +: GAP_W]; period = gap+1 cycles.
- `user_ofs`  in  NCH*GAP_W  first-pulse delay in cycles.
- `user_wid`  in  NCH*WID_W  pulse high width in cycles.
- `user_nburst`  in  NCH*NB_W  pulses per burst; 0 = continuous.
- `out`  out  NCH  trigger outputs, registered.
- `active`  out  NCH  channel in DELAY or RUN, registered.
- `done`  out  NCH  one-cycle strobe on burst completion, registered.

## Operation
- Per-channel FSM: IDLE, DELAY, RUN, DONE. Channels are fully independent except for the shared `in_live`, `sync` and reset.
- Config (gap, ofs, wid, nburst) is latched into shadow registers on the start edge. Input changes during DELAY, RUN or DONE are ignored until the next start.
- Start edge: first edge with `in_live`=1, `user_ena[c]`=1 and the channel in IDLE.
  - ofs=0: go to RUN.
  - ofs>0: go to DELAY.
- DELAY: counts ofs cycles, then enters RUN; the first pulse begins at edge E0+ofs.
- RUN: phase counter runs 0..gap and wraps to 0.
  - `out`=1 while phase < wid_eff.
  - wid_eff = max(wid,1), clamped to gap+1. So gap=0 or wid ≥ gap+1 gives a continuously high `out`.
  - Each wrap counts one completed pulse.
- Burst (nburst>0): when phase wraps after pulse nburst, go to DONE. `done` is high for exactly that cycle and `out`=0.
- Continuous (nburst=0): RUN indefinitely.
- DONE: `out`=0, `active`=0. Holds until `user_ena[c]`=0 or `in_live`=0, which returns the channel to IDLE. The enable must be re-asserted to rearm.
- `sync`=1 with `in_live`=1: every channel with `user_ena`=1 in DELAY, RUN or DONE relatches config and restarts exactly as on a start edge (burst count cleared). Channels in IDLE with ena=1 start normally on the same edge.
- Priority per channel, highest first: `rst_n`; (`in_live`=0 or ena=0 → IDLE); `sync`; normal FSM.
- Counters are unsigned. Phase and delay counters are GAP_W bits and the pulse counter is NB_W bits; none can overflow given the clamps above.

## Timing
- Reset values: `out`=0, `active`=0, `done`=0; all FSMs IDLE; counters and shadows 0.
- E0 = start edge. `out` rises at edge E0+ofs+k*(gap+1) for k=0..nburst-1 (unbounded k if nburst=0) and stays high wid_eff cycles.
- DONE entry and `done` strobe occur at edge E0+ofs+nburst*(gap+1).
- `active` rises at E0 and falls at the DONE entry edge or the IDLE-forcing edge.
- With ofs=0, wid=1, nburst=0, channel behaviour is cycle-identical to the legacy single-channel trigger: pulse at E0, period gap+1.
- Gate drop: `out`=0 and `active`=0 at the edge sampling `in_live`=0 or ena=0. No partial pulse extends past it.
- `rst_n` low mid-operation clears outputs immediately (asynchronous). The first start is possible at the first edge after release.
- A `sync` edge resets phase so that `out`=1 at that edge when ofs=0. Any pulse in progress is truncated or restarted.

## Test plan
- Legacy: ch0 gap=4, ofs=0, wid=1, nburst=0, ena high at E0 → `out[0]` high at E0, E0+5, E0+10…, one cycle each.
- Offset/width/burst: ch1 gap=9, ofs=3, wid=4, nburst=3 → `out[1]` high on cycles 3–6, 13–16, 23–26. `done[1]` strobe and DONE at edge 33. `out[1]`=0 thereafter until ena toggles.
- Clamp: gap=2, wid=0 → 1-cycle pulses. Gap=2, wid=200 → `out` constantly high. Gap=0 → constantly high.
- Shadowing: change ch2 gap 7→3 mid-run → period stays 8 until ena cycled, then becomes 4.
- Sync: ch0 gap=4 and ch1 gap=6 running at arbitrary phases, `sync` pulse at edge S → both pulse at S (ofs=0), ch1 then at S+7. A channel in DONE restarts at S.
- Gating/reset: drop `in_live` mid-pulse → all `out`/`active`=0 next edge. Assert `rst_n`=0 asynchronously mid-DELAY → outputs 0 with no clock. After release, restart obeys the offset from the new E0.
